// File: rtl/rtlupmst.sv
`default_nettype none
// ============================================================================
//  Module      : rtlupmst
//  Description : Host-side initiator for the upen/upws/uprs/upa/updi/updo/
//                uprdy slave bus. Runs one host transaction at a time: issues
//                a single-cycle strobe, holds the enable while waiting for
//                uprdy, returns read data and aborts hung accesses by timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtlupmst #(
    parameter int ADDRBIT = 5,
    parameter int WIDTH   = 32,
    parameter int TOBIT   = 8,
    parameter int TOVAL   = 255
) (
    input  logic               clk,
    input  logic               rst,
    // host side
    input  logic               hst_req,
    input  logic               hst_wr,
    input  logic [ADDRBIT-1:0] hst_addr,
    input  logic [WIDTH-1:0]   hst_wdat,
    output logic               hst_busy,
    output logic               hst_ack,
    output logic               hst_err,
    output logic [WIDTH-1:0]   hst_rdat,
    // slave side
    output logic               upen,
    output logic               upws,
    output logic               uprs,
    output logic [ADDRBIT-1:0] upa,
    output logic [WIDTH-1:0]   updi,
    input  logic [WIDTH-1:0]   updo,
    input  logic               uprdy
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_STRB = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // Counter value seen during the last permitted WAIT cycle (counter is 0
    // in the first WAIT cycle).
    localparam logic [TOBIT-1:0] c_CNT_LAST = TOBIT'(TOVAL - 1);
    localparam logic [TOBIT-1:0] c_CNT_ONE  = TOBIT'(1);

    logic [1:0]         r_state;
    logic               r_wr;
    logic [TOBIT-1:0]   r_cnt;

    logic [1:0]         w_state_nxt;
    logic               w_wr_nxt;
    logic [TOBIT-1:0]   w_cnt_nxt;
    logic               w_busy_nxt;
    logic               w_ack_nxt;
    logic               w_err_nxt;
    logic [WIDTH-1:0]   w_rdat_nxt;
    logic               w_upen_nxt;
    logic               w_upws_nxt;
    logic               w_uprs_nxt;
    logic [ADDRBIT-1:0] w_upa_nxt;
    logic [WIDTH-1:0]   w_updi_nxt;

    // Next-state and next-output decode; every output is computed one cycle
    // ahead so that the ports themselves come straight from flops.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_nxt    = r_wr;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = hst_busy;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = hst_err;
        w_rdat_nxt  = hst_rdat;
        w_upen_nxt  = upen;
        w_upws_nxt  = 1'b0;
        w_uprs_nxt  = 1'b0;
        w_upa_nxt   = upa;
        w_updi_nxt  = updi;

        case (r_state)
            c_ST_IDLE: begin
                if (hst_req) begin
                    w_state_nxt = c_ST_STRB;
                    w_wr_nxt    = hst_wr;
                    w_upa_nxt   = hst_addr;
                    w_updi_nxt  = hst_wdat;
                    w_upen_nxt  = 1'b1;
                    w_upws_nxt  = hst_wr;
                    w_uprs_nxt  = ~hst_wr;
                    w_busy_nxt  = 1'b1;
                end
            end

            c_ST_STRB: begin
                // Strobe lasts exactly one cycle; the slave latches it.
                w_state_nxt = c_ST_WAIT;
                w_cnt_nxt   = '0;
                w_upen_nxt  = 1'b1;
                w_busy_nxt  = 1'b1;
            end

            c_ST_WAIT: begin
                w_busy_nxt = 1'b1;
                if (uprdy) begin
                    // Completion beats a simultaneous timeout.
                    w_state_nxt = c_ST_DONE;
                    w_upen_nxt  = 1'b0;
                    w_ack_nxt   = 1'b1;
                    w_err_nxt   = 1'b0;
                    if (!r_wr) begin
                        w_rdat_nxt = updo;
                    end
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_DONE;
                    w_upen_nxt  = 1'b0;
                    w_ack_nxt   = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_rdat_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            c_ST_DONE: begin
                // Ack is visible during this cycle; return to idle.
                w_state_nxt = c_ST_IDLE;
                w_err_nxt   = 1'b0;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_upen_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_wr     <= 1'b0;
            r_cnt    <= '0;
            hst_busy <= 1'b0;
            hst_ack  <= 1'b0;
            hst_err  <= 1'b0;
            hst_rdat <= '0;
            upen     <= 1'b0;
            upws     <= 1'b0;
            uprs     <= 1'b0;
            upa      <= '0;
            updi     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr     <= w_wr_nxt;
            r_cnt    <= w_cnt_nxt;
            hst_busy <= w_busy_nxt;
            hst_ack  <= w_ack_nxt;
            hst_err  <= w_err_nxt;
            hst_rdat <= w_rdat_nxt;
            upen     <= w_upen_nxt;
            upws     <= w_upws_nxt;
            uprs     <= w_uprs_nxt;
            upa      <= w_upa_nxt;
            updi     <= w_updi_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rtlupmst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtlupmst
//  Description : Scoreboard bench for rtlupmst with directed transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtlupmst;

    localparam int ADDRBIT = 5;
    localparam int WIDTH   = 32;
    localparam int TOBIT   = 8;
    localparam int TOVAL   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               hst_req;
    logic               hst_wr;
    logic [ADDRBIT-1:0] hst_addr;
    logic [WIDTH-1:0]   hst_wdat;
    logic               hst_busy;
    logic               hst_ack;
    logic               hst_err;
    logic [WIDTH-1:0]   hst_rdat;
    logic               upen;
    logic               upws;
    logic               uprs;
    logic [ADDRBIT-1:0] upa;
    logic [WIDTH-1:0]   updi;
    logic [WIDTH-1:0]   updo;
    logic               uprdy;

    rtlupmst #(
        .ADDRBIT (ADDRBIT),
        .WIDTH   (WIDTH),
        .TOBIT   (TOBIT),
        .TOVAL   (TOVAL)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .hst_req  (hst_req),
        .hst_wr   (hst_wr),
        .hst_addr (hst_addr),
        .hst_wdat (hst_wdat),
        .hst_busy (hst_busy),
        .hst_ack  (hst_ack),
        .hst_err  (hst_err),
        .hst_rdat (hst_rdat),
        .upen     (upen),
        .upws     (upws),
        .uprs     (uprs),
        .upa      (upa),
        .updi     (updi),
        .updo     (updo),
        .uprdy    (uprdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 strb_cyc;
        int                 ack_cyc;
        bit                 wr;
        logic [ADDRBIT-1:0] addr;
        logic [WIDTH-1:0]   wdat;
        bit                 err;
        logic [WIDTH-1:0]   rdat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   strb_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Monitor: checks strobes, the enable window and every ack against the
    // head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            strb_cnt = 0;
        end else begin
            if (sb.size() > 0 && cyc >= sb[0].strb_cyc && cyc < sb[0].ack_cyc) begin
                chk("upen_window", upen, 1'b1);
                chk("busy_window", hst_busy, 1'b1);
                chk("upa_hold", upa, sb[0].addr);
                chk("updi_hold", updi, sb[0].wdat);
            end
            if (upws || uprs) begin
                strb_cnt++;
                if (sb.size() > 0) begin
                    chk("strb_cycle", cyc, sb[0].strb_cyc);
                    chk("strb_ws", upws, sb[0].wr);
                    chk("strb_rs", uprs, !sb[0].wr);
                end
            end
            if (hst_ack) begin
                chk("ack_expected", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_cycle", cyc, e.ack_cyc);
                    chk("ack_err", hst_err, e.err);
                    chk("ack_rdat", hst_rdat, e.rdat);
                    chk("ack_upen_low", upen, 1'b0);
                    chk("strobes_per_txn", strb_cnt, 1);
                end
                strb_cnt = 0;
            end
        end
    end

    // Issue one transaction in the current cycle; rdy_rel < 0 means a mute slave.
    task automatic run_txn(input bit wr, input logic [ADDRBIT-1:0] addr,
                           input logic [WIDTH-1:0] wdat, input int rdy_rel,
                           input logic [WIDTH-1:0] rdo, input bit e_err,
                           input logic [WIDTH-1:0] e_rdat);
        exp_t e;
        int   c0;
        c0 = cyc;
        hst_req  = 1'b1;
        hst_wr   = wr;
        hst_addr = addr;
        hst_wdat = wdat;
        e.strb_cyc = c0 + 1;
        e.ack_cyc  = (rdy_rel >= 0) ? c0 + rdy_rel + 1 : c0 + TOVAL + 2;
        e.wr   = wr;
        e.addr = addr;
        e.wdat = wdat;
        e.err  = e_err;
        e.rdat = e_rdat;
        sb.push_back(e);
        tick();
        hst_req = 1'b0;
        if (rdy_rel >= 0) begin
            wait_until(c0 + rdy_rel);
            uprdy = 1'b1;
            updo  = rdo;
            tick();
            uprdy = 1'b0;
            updo  = '0;
        end
        wait_until(e.ack_cyc + 1);
    endtask

    initial begin
        int   c0;
        int   acks;
        exp_t e;

        rst = 1'b1; hst_req = 1'b0; hst_wr = 1'b0; hst_addr = '0; hst_wdat = '0;
        updo = '0; uprdy = 1'b0;
        repeat (3) tick();
        chk("rst_busy", hst_busy, 1'b0);
        chk("rst_ack", hst_ack, 1'b0);
        chk("rst_upen", upen, 1'b0);
        chk("rst_rdat", hst_rdat, 32'h0);
        chk("rst_upa", upa, 5'h0);
        rst = 1'b0;
        repeat (2) tick();

        // write, slave responds in cycle 6 -> ack in 7
        run_txn(1'b1, 5'h0A, 32'hDEADBEEF, 6, 32'h0, 1'b0, 32'h0);
        // read, uprdy in cycle 5 -> ack in 6 with data
        run_txn(1'b0, 5'h03, 32'h0, 5, 32'h12345678, 1'b0, 32'h12345678);
        // fastest write (uprdy in first WAIT cycle); read data must be held
        run_txn(1'b1, 5'h11, 32'hCAFEF00D, 2, 32'hFFFFFFFF, 1'b0, 32'h12345678);

        // timeout on a mute slave, then a stale uprdy that must be ignored
        c0 = cyc;
        run_txn(1'b0, 5'h1F, 32'h0, -1, 32'h0, 1'b1, 32'h0);
        wait_until(c0 + 20);
        uprdy = 1'b1; updo = 32'h77777777;
        tick();
        uprdy = 1'b0; updo = '0;
        chk("stale_no_ack", hst_ack, 1'b0);
        chk("stale_idle", hst_busy, 1'b0);
        tick();
        chk("stale_no_ack2", hst_ack, 1'b0);

        // tie: uprdy in the last permitted WAIT cycle wins over timeout
        run_txn(1'b0, 5'h06, 32'h0, TOVAL + 1, 32'hAABBCCDD, 1'b0, 32'hAABBCCDD);

        // back-to-back with hst_req held high: read then write
        tick();
        c0 = cyc;
        hst_req = 1'b1; hst_wr = 1'b0; hst_addr = 5'h04; hst_wdat = 32'h0;
        e.strb_cyc = c0 + 1; e.ack_cyc = c0 + 4; e.wr = 1'b0; e.addr = 5'h04;
        e.wdat = 32'h0; e.err = 1'b0; e.rdat = 32'h0BADF00D;
        sb.push_back(e);
        e.strb_cyc = c0 + 6; e.ack_cyc = c0 + 9; e.wr = 1'b1; e.addr = 5'h05;
        e.wdat = 32'h00000055; e.err = 1'b0; e.rdat = 32'h0BADF00D;
        sb.push_back(e);
        tick();
        hst_addr = 5'h1E; hst_wr = 1'b1; hst_wdat = 32'h99999999;
        wait_until(c0 + 3);
        uprdy = 1'b1; updo = 32'h0BADF00D;
        tick();
        uprdy = 1'b0; updo = '0;
        wait_until(c0 + 5);
        hst_wr = 1'b1; hst_addr = 5'h05; hst_wdat = 32'h00000055;
        tick();
        tick();
        hst_req = 1'b0;
        wait_until(c0 + 8);
        uprdy = 1'b1;
        tick();
        uprdy = 1'b0;
        wait_until(c0 + 12);
        chk("b2b_drained", sb.size(), 0);

        // reset in the middle of WAIT aborts without an ack
        c0 = cyc;
        hst_req = 1'b1; hst_wr = 1'b0; hst_addr = 5'h07; hst_wdat = 32'h0;
        tick();
        hst_req = 1'b0;
        wait_until(c0 + 4);
        chk("abort_upen_before", upen, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_upen_after", upen, 1'b0);
        chk("abort_busy_after", hst_busy, 1'b0);
        chk("abort_rdat_after", hst_rdat, 32'h0);
        acks = 0;
        repeat (24) begin
            if (hst_ack) acks++;
            tick();
        end
        chk("abort_no_ack", acks, 0);
        run_txn(1'b0, 5'h09, 32'h0, 4, 32'h13579BDF, 1'b0, 32'h13579BDF);

        repeat (3) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
